gpio_wb: RTL and testbench

- Wishbone-classic slave GPIO controller inside globefish_soc.
- Directly produces the gpo/gpeo/gpcs/gpsl/gppu/gppd vectors that drive the chip's programmable GPIO pads, and consumes gpi from those pads.
- Adds a 2-flop input synchronizer, rising/falling edge detection and a level interrupt for the CPU.

---
 rtl/gpio_wb.sv | 171 +++++++++++++++++
 tb/tb_gpio_wb.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/gpio_wb.sv
// gpio_wb: Wishbone-classic slave GPIO controller.
//
// Drives the programmable pad controls (output value, output enable, Schmitt
// select, slew, pull-up, pull-down) from bus-writable registers. The pad
// inputs pass through a 2-flop synchronizer and then an edge detector. The
// edge detector sets per-pin sticky PENDING bits, and irq_o is the OR of them.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i Wishbone classic control
//   wb_adr_i[5:2]       word select; wb_sel_i[0] gates writes
//   wb_dat_i/wb_dat_o   write / read data (data in [NUM_GPIO-1:0])
//   wb_ack_o            one-cycle acknowledge, cycle after the request
//   gpi_i               asynchronous pad inputs
//   gpo_o .. gppd_o     pad control vectors
//   irq_o               level interrupt, OR of PENDING
//
// Register map (byte offset):
//   0x00 GPO, 0x04 GPEO, 0x08 GPCS, 0x0C GPSL, 0x10 GPPU, 0x14 GPPD (RW)
//   0x18 GPI (RO, synchronized), 0x1C RISE_EN, 0x20 FALL_EN (RW)
//   0x24 PENDING (write-1-to-clear), 0x28..0x3C unmapped (read 0)

module gpio_wb #(
    parameter int unsigned          NUM_GPIO = 4,
    parameter logic [NUM_GPIO-1:0]  SL_RST   = {NUM_GPIO{1'b1}}
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic                wb_we_i,
    input  logic [5:0]          wb_adr_i,
    input  logic [3:0]          wb_sel_i,
    input  logic [31:0]         wb_dat_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,

    input  logic [NUM_GPIO-1:0] gpi_i,
    output logic [NUM_GPIO-1:0] gpo_o,
    output logic [NUM_GPIO-1:0] gpeo_o,
    output logic [NUM_GPIO-1:0] gpcs_o,
    output logic [NUM_GPIO-1:0] gpsl_o,
    output logic [NUM_GPIO-1:0] gppu_o,
    output logic [NUM_GPIO-1:0] gppd_o,
    output logic                irq_o
);

    localparam logic [3:0] AddrGpo     = 4'h0;
    localparam logic [3:0] AddrGpeo    = 4'h1;
    localparam logic [3:0] AddrGpcs    = 4'h2;
    localparam logic [3:0] AddrGpsl    = 4'h3;
    localparam logic [3:0] AddrGppu    = 4'h4;
    localparam logic [3:0] AddrGppd    = 4'h5;
    localparam logic [3:0] AddrGpi     = 4'h6;
    localparam logic [3:0] AddrRiseEn  = 4'h7;
    localparam logic [3:0] AddrFallEn  = 4'h8;
    localparam logic [3:0] AddrPending = 4'h9;

    // Bus state
    logic                ack_q;
    logic [31:0]         dat_q;

    // Control registers
    logic [NUM_GPIO-1:0] gpo_q, gpeo_q, gpcs_q, gpsl_q, gppu_q, gppd_q;
    logic [NUM_GPIO-1:0] rise_en_q, fall_en_q, pending_q;

    // Input path: s1/s2 synchronizer, prev holds s2 from the previous cycle
    logic [NUM_GPIO-1:0] sync1_q, sync2_q, prev_q;

    logic                req;
    logic                wr_en;
    logic [3:0]          addr;
    logic [NUM_GPIO-1:0] wdata;
    logic [NUM_GPIO-1:0] rdata;
    logic [31:0]         rdata_ext;
    logic [NUM_GPIO-1:0] w1c_mask;
    logic [NUM_GPIO-1:0] rise, fall;
    logic [NUM_GPIO-1:0] pending_d;
    logic [31:0]         dat_d;

    // Bits of the bus that the register file never looks at
    logic unused_bus;
    assign unused_bus = ^{wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:NUM_GPIO]};

    // ack_q masks the request so a held cyc/stb is acked every other cycle
    assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr_en = req & wb_we_i & wb_sel_i[0];
    assign addr  = wb_adr_i[5:2];
    assign wdata = wb_dat_i[NUM_GPIO-1:0];

    always_comb begin
        rdata = '0;
        case (addr)
            AddrGpo:     rdata = gpo_q;
            AddrGpeo:    rdata = gpeo_q;
            AddrGpcs:    rdata = gpcs_q;
            AddrGpsl:    rdata = gpsl_q;
            AddrGppu:    rdata = gppu_q;
            AddrGppd:    rdata = gppd_q;
            AddrGpi:     rdata = sync2_q;
            AddrRiseEn:  rdata = rise_en_q;
            AddrFallEn:  rdata = fall_en_q;
            AddrPending: rdata = pending_q;
            default:     rdata = '0;
        endcase
    end

    assign rdata_ext = {{(32 - NUM_GPIO){1'b0}}, rdata};

    // Read data is only presented alongside the ack; otherwise the bus is 0
    assign dat_d = req ? rdata_ext : 32'h0;

    assign w1c_mask = (wr_en && (addr == AddrPending)) ? wdata : '0;

    assign rise = sync2_q & ~prev_q & rise_en_q;
    assign fall = ~sync2_q & prev_q & fall_en_q;

    // New events are OR-ed in after the clear, so a set beats a same-cycle W1C
    assign pending_d = (pending_q & ~w1c_mask) | rise | fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'h0;
            gpo_q     <= '0;
            gpeo_q    <= '0;
            gpcs_q    <= '0;
            gpsl_q    <= SL_RST;
            gppu_q    <= '0;
            gppd_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pending_q <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
        end else begin
            ack_q     <= req;
            dat_q     <= dat_d;
            sync1_q   <= gpi_i;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
            if (wr_en) begin
                case (addr)
                    AddrGpo:    gpo_q     <= wdata;
                    AddrGpeo:   gpeo_q    <= wdata;
                    AddrGpcs:   gpcs_q    <= wdata;
                    AddrGpsl:   gpsl_q    <= wdata;
                    AddrGppu:   gppu_q    <= wdata;
                    AddrGppd:   gppd_q    <= wdata;
                    AddrRiseEn: rise_en_q <= wdata;
                    AddrFallEn: fall_en_q <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_dat_o = dat_q;
    assign gpo_o    = gpo_q;
    assign gpeo_o   = gpeo_q;
    assign gpcs_o   = gpcs_q;
    assign gpsl_o   = gpsl_q;
    assign gppu_o   = gppu_q;
    assign gppd_o   = gppd_q;
    assign irq_o    = |pending_q;

endmodule

// File: tb/tb_gpio_wb.sv
module tb_gpio_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [5:0]  adr = '0;
    logic [3:0]  sel = '0;
    logic [31:0] wdat = '0;
    logic [31:0] rdat;
    logic        ack;
    logic [3:0]  gpi = '0;
    logic [3:0]  gpo, gpeo, gpcs, gpsl, gppu, gppd;
    logic        irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gpio_wb #(.NUM_GPIO(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .wb_cyc_i (cyc),
        .wb_stb_i (stb),
        .wb_we_i  (we),
        .wb_adr_i (adr),
        .wb_sel_i (sel),
        .wb_dat_i (wdat),
        .wb_dat_o (rdat),
        .wb_ack_o (ack),
        .gpi_i    (gpi),
        .gpo_o    (gpo),
        .gpeo_o   (gpeo),
        .gpcs_o   (gpcs),
        .gpsl_o   (gpsl),
        .gppu_o   (gppu),
        .gppd_o   (gppd),
        .irq_o    (irq)
    );

    typedef struct {
        logic        we;
        logic [5:0]  adr;
        logic        sel;
        logic [31:0] wdat;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic [23:0] exp_pads;   // {gpo, gpeo, gpcs, gpsl, gppu, gppd}
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns in the ack cycle with
    // the request already withdrawn. Caller must tick() before the next op.
    task automatic bus(input logic w, input logic [5:0] a, input logic s,
                       input logic [31:0] d, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = {3'b000, s}; wdat = d;
        tick();
        check("ack", {31'h0, ack}, 32'h1);
        rd = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
    endtask

    logic [31:0] rd;

    initial begin
        vecs[0]  = '{1'b0, 6'h0C, 1'b1, 32'h0,        1'b1, 32'hF, 24'h000F00};
        vecs[1]  = '{1'b1, 6'h00, 1'b1, 32'hA,        1'b0, 32'h0, 24'hA00F00};
        vecs[2]  = '{1'b1, 6'h04, 1'b1, 32'h5,        1'b0, 32'h0, 24'hA50F00};
        vecs[3]  = '{1'b0, 6'h00, 1'b1, 32'h0,        1'b1, 32'hA, 24'hA50F00};
        vecs[4]  = '{1'b0, 6'h04, 1'b1, 32'h0,        1'b1, 32'h5, 24'hA50F00};
        vecs[5]  = '{1'b1, 6'h00, 1'b0, 32'h3,        1'b0, 32'h0, 24'hA50F00};
        vecs[6]  = '{1'b1, 6'h04, 1'b0, 32'hF,        1'b0, 32'h0, 24'hA50F00};
        vecs[7]  = '{1'b0, 6'h00, 1'b1, 32'h0,        1'b1, 32'hA, 24'hA50F00};
        vecs[8]  = '{1'b1, 6'h08, 1'b1, 32'h6,        1'b0, 32'h0, 24'hA56F00};
        vecs[9]  = '{1'b1, 6'h0C, 1'b1, 32'h2,        1'b0, 32'h0, 24'hA56200};
        vecs[10] = '{1'b1, 6'h10, 1'b1, 32'h9,        1'b0, 32'h0, 24'hA56290};
        vecs[11] = '{1'b1, 6'h14, 1'b1, 32'hC,        1'b0, 32'h0, 24'hA5629C};
        vecs[12] = '{1'b0, 6'h30, 1'b1, 32'h0,        1'b1, 32'h0, 24'hA5629C};
        vecs[13] = '{1'b1, 6'h3C, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 24'hA5629C};
        vecs[14] = '{1'b0, 6'h0C, 1'b1, 32'h0,        1'b1, 32'h2, 24'hA5629C};
        vecs[15] = '{1'b1, 6'h00, 1'b1, 32'hFFFFFFF5, 1'b0, 32'h0, 24'h55629C};
        vecs[16] = '{1'b0, 6'h00, 1'b1, 32'h0,        1'b1, 32'h5, 24'h55629C};

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        check("rst_pads", {8'h0, gpo, gpeo, gpcs, gpsl, gppu, gppd}, 32'h000F00);

        // Register vectors
        for (int i = 0; i < 17; i++) begin
            bus(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].wdat, rd);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
            check($sformatf("vec%0d_pads", i), {8'h0, gpo, gpeo, gpcs, gpsl, gppu, gppd},
                  {8'h0, vecs[i].exp_pads});
            tick();
            check($sformatf("vec%0d_ack_low", i), {31'h0, ack}, 32'h0);
        end

        // Rising edge on bit 0: sync latency and irq timing
        bus(1'b1, 6'h1C, 1'b1, 32'h1, rd); tick();
        gpi[0] = 1'b1;
        tick();                                     // s1 = 1
        check("rise_irq_t1", {31'h0, irq}, 32'h0);
        bus(1'b0, 6'h18, 1'b1, 32'h0, rd);          // request sees s2 = 0
        check("rise_gpi_early", rd, 32'h0);
        check("rise_irq_t2", {31'h0, irq}, 32'h0);
        tick();
        check("rise_irq_t3", {31'h0, irq}, 32'h1);
        bus(1'b0, 6'h18, 1'b1, 32'h0, rd); tick();
        check("rise_gpi", rd, 32'h1);
        repeat (4) tick();
        bus(1'b0, 6'h24, 1'b1, 32'h0, rd); tick();
        check("rise_pending_hold", rd, 32'h1);
        bus(1'b1, 6'h24, 1'b1, 32'h1, rd);
        check("rise_w1c_irq", {31'h0, irq}, 32'h0);
        tick();

        // Falling edge on bit 3 then W1C
        gpi[3] = 1'b1;
        repeat (4) tick();
        check("fall_none_yet", {31'h0, irq}, 32'h0);
        bus(1'b1, 6'h20, 1'b1, 32'h8, rd); tick();
        gpi[3] = 1'b0;
        repeat (4) tick();
        bus(1'b0, 6'h24, 1'b1, 32'h0, rd); tick();
        check("fall_pending", rd, 32'h8);
        check("fall_irq", {31'h0, irq}, 32'h1);
        bus(1'b1, 6'h24, 1'b1, 32'h8, rd);
        check("fall_w1c_irq", {31'h0, irq}, 32'h0);
        tick();
        bus(1'b0, 6'h24, 1'b1, 32'h0, rd); tick();
        check("fall_pending_clr", rd, 32'h0);

        // Set vs W1C collision on bit 1
        bus(1'b1, 6'h1C, 1'b1, 32'h3, rd); tick();
        gpi[1] = 1'b1;
        repeat (4) tick();
        gpi[1] = 1'b0;
        repeat (4) tick();
        check("coll_pre_irq", {31'h0, irq}, 32'h1);
        gpi[1] = 1'b1;
        tick();
        tick();                                     // rise detected this cycle
        bus(1'b1, 6'h24, 1'b1, 32'h2, rd);
        check("coll_irq", {31'h0, irq}, 32'h1);
        tick();
        bus(1'b0, 6'h24, 1'b1, 32'h0, rd); tick();
        check("coll_pending", rd, 32'h2);
        bus(1'b1, 6'h24, 1'b1, 32'h2, rd); tick();
        check("coll_clear_irq", {31'h0, irq}, 32'h0);

        // Continuous cyc/stb: ack 0,1,0,1
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 6'h00; sel = 4'h1;
        check("cont_ack0", {31'h0, ack}, 32'h0);
        tick(); check("cont_ack1", {31'h0, ack}, 32'h1);
        tick(); check("cont_ack2", {31'h0, ack}, 32'h0);
        tick(); check("cont_ack3", {31'h0, ack}, 32'h1);
        cyc = 1'b0; stb = 1'b0;
        tick(); check("cont_ack_end", {31'h0, ack}, 32'h0);

        // Write to read-only GPI is ignored
        bus(1'b1, 6'h18, 1'b1, 32'hC, rd); tick();
        bus(1'b0, 6'h18, 1'b1, 32'h0, rd); tick();
        check("gpi_ro", rd, 32'h3);

        // Reset in the request cycle drops the request
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 6'h00; sel = 4'h1; wdat = 32'hA;
        rst = 1'b1;
        tick();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; rst = 1'b0;
        check("mrst_ack0", {31'h0, ack}, 32'h0);
        tick();
        check("mrst_ack1", {31'h0, ack}, 32'h0);
        check("mrst_pads", {8'h0, gpo, gpeo, gpcs, gpsl, gppu, gppd}, 32'h000F00);
        check("mrst_irq", {31'h0, irq}, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
